// File: rtl/clk_phase_pkg.sv
// Shared definitions for the multi-phase clock-enable generator.
//   LVL/RISE/FALL : bit positions inside a 3-bit clock bundle {fall,rise,level}
//   phase_level() : level of a divided clock for a given counter value,
//                   phase offset and divider (all modulo arithmetic unsigned)
package clk_phase_pkg;

    localparam int unsigned LVL  = 0;
    localparam int unsigned RISE = 1;
    localparam int unsigned FALL = 2;

    // High for the first half of the period that starts at 'offset'.
    // Adding div before subtracting keeps every intermediate non-negative.
    function automatic logic phase_level(input logic [31:0] cnt,
                                         input int unsigned offset,
                                         input int unsigned div);
        logic [31:0] c;
        logic [31:0] o;
        c = cnt % div;
        o = offset % div;
        return ((c + div - o) % div) < (div / 2);
    endfunction

endpackage

// File: rtl/clk_phase_lane.sv
// One output lane of the clock-enable generator: registers level, rise pulse
// and fall pulse of a clock derived from the shared phase counter.
//   clk      : system clock
//   rst      : synchronous reset, active-low
//   adv      : counter advances this cycle
//   cnt_next : counter value being loaded this cycle
//   bundle   : {fall, rise, level}
module clk_phase_lane
    import clk_phase_pkg::*;
#(
    parameter int unsigned CW     = 3,
    parameter int unsigned OFFSET = 0,
    parameter int unsigned LDIV   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv,
    input  logic [CW-1:0] cnt_next,
    output logic [2:0]    bundle
);

    logic lvl_next;

    always_comb begin
        lvl_next = phase_level(32'(cnt_next), OFFSET, LDIV);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bundle[LVL]  <= phase_level(32'd0, OFFSET, LDIV);
            bundle[RISE] <= 1'b0;
            bundle[FALL] <= 1'b0;
        end else if (adv) begin
            bundle[LVL]  <= lvl_next;
            bundle[RISE] <= lvl_next & ~bundle[LVL];
            bundle[FALL] <= ~lvl_next & bundle[LVL];
        end else begin
            // Level holds; pulses last exactly one main_clk.
            bundle[RISE] <= 1'b0;
            bundle[FALL] <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_phase_gen.sv
// Parametrised multi-phase clock-enable generator. A phase counter advanced by
// the 28 MHz strobe drives NPH equally spaced CCK-rate phases plus a fast
// C7M/CDAC pair. Supports runtime resync, clock stretching and a lock flag.
//   main_clk  : system clock
//   main_rst  : synchronous reset, active-low
//   ena_28m   : one-cycle advance strobe
//   sync_req  : load SYNC_VAL at the current or next advance
//   stretch   : discard advances while high
//   phases    : phase k at [3k+2:3k] as {fall,rise,level}
//   c7m/cdac  : fast clock bundles, cdac lagging by FDIV/4 advances
//   phase_cnt : current counter value
//   locked    : a full period has elapsed since reset or resync
module clk_phase_gen
    import clk_phase_pkg::*;
#(
    parameter int unsigned DIV      = 8,
    parameter int unsigned NPH      = 4,
    parameter int unsigned FDIV     = 4,
    parameter int unsigned SYNC_VAL = 0,
    localparam int unsigned CW      = $clog2(DIV)
) (
    input  logic             main_clk,
    input  logic             main_rst,
    input  logic             ena_28m,
    input  logic             sync_req,
    input  logic             stretch,
    output logic [3*NPH-1:0] phases,
    output logic [2:0]       c7m,
    output logic [2:0]       cdac,
    output logic [CW-1:0]    phase_cnt,
    output logic             locked
);

    localparam int unsigned   S        = DIV / NPH;
    localparam logic [CW-1:0] LAST     = CW'(DIV - 1);
    localparam logic [CW-1:0] SYNC_CNT = CW'(SYNC_VAL);
    localparam logic [CW:0]   LOCK_MAX = (CW+1)'(DIV);

    logic          adv;
    logic          apply_sync;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          pending;
    logic [CW:0]   lock_ctr;

    always_comb begin
        adv        = ena_28m & ~stretch;
        apply_sync = sync_req | pending;
        cnt_next   = cnt;
        if (adv) begin
            if (apply_sync) begin
                cnt_next = SYNC_CNT;
            end else if (cnt == LAST) begin
                cnt_next = '0;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge main_clk) begin
        if (!main_rst) begin
            cnt      <= '0;
            pending  <= 1'b0;
            lock_ctr <= '0;
            locked   <= 1'b0;
        end else begin
            cnt <= cnt_next;
            if (adv) begin
                pending <= 1'b0;
                if (apply_sync) begin
                    lock_ctr <= '0;
                    locked   <= 1'b0;
                end else if (lock_ctr != LOCK_MAX) begin
                    lock_ctr <= lock_ctr + 1'b1;
                    locked   <= (lock_ctr + 1'b1) == LOCK_MAX;
                end
            end else if (sync_req) begin
                // Request arriving without an advance (e.g. during stretch)
                // is held until the next advance.
                pending <= 1'b1;
            end
        end
    end

    assign phase_cnt = cnt;

    for (genvar k = 0; k < NPH; k++) begin : g_phase
        clk_phase_lane #(
            .CW    (CW),
            .OFFSET(k * S),
            .LDIV  (DIV)
        ) u_lane (
            .clk     (main_clk),
            .rst     (main_rst),
            .adv     (adv),
            .cnt_next(cnt_next),
            .bundle  (phases[3*k +: 3])
        );
    end

    clk_phase_lane #(
        .CW    (CW),
        .OFFSET(0),
        .LDIV  (FDIV)
    ) u_c7m (
        .clk     (main_clk),
        .rst     (main_rst),
        .adv     (adv),
        .cnt_next(cnt_next),
        .bundle  (c7m)
    );

    clk_phase_lane #(
        .CW    (CW),
        .OFFSET(FDIV / 4),
        .LDIV  (FDIV)
    ) u_cdac (
        .clk     (main_clk),
        .rst     (main_rst),
        .adv     (adv),
        .cnt_next(cnt_next),
        .bundle  (cdac)
    );

endmodule

// File: tb/tb_clk_phase_gen.sv
module tb_clk_phase_gen;

    localparam int DIV      = 8;
    localparam int NPH      = 4;
    localparam int FDIV     = 4;
    localparam int SYNC_VAL = 0;
    localparam int CW       = $clog2(DIV);
    localparam int S        = DIV / NPH;
    localparam int NL       = NPH + 2;
    localparam int AW       = CW + 1 + 3*NPH + 6;

    logic             main_clk = 1'b0;
    logic             main_rst;
    logic             ena_28m;
    logic             sync_req;
    logic             stretch;
    logic [3*NPH-1:0] phases;
    logic [2:0]       c7m;
    logic [2:0]       cdac;
    logic [CW-1:0]    phase_cnt;
    logic             locked;

    clk_phase_gen #(
        .DIV     (DIV),
        .NPH     (NPH),
        .FDIV    (FDIV),
        .SYNC_VAL(SYNC_VAL)
    ) dut (
        .main_clk (main_clk),
        .main_rst (main_rst),
        .ena_28m  (ena_28m),
        .sync_req (sync_req),
        .stretch  (stretch),
        .phases   (phases),
        .c7m      (c7m),
        .cdac     (cdac),
        .phase_cnt(phase_cnt),
        .locked   (locked)
    );

    always #5 main_clk = ~main_clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Behavioural reference: counter as an integer, lanes described by
    // (offset, divider) pairs, levels from the half-period rule.
    int m_cnt;
    bit m_pend;
    int m_lock;
    bit m_lvl  [NL];
    bit m_rise [NL];
    bit m_fall [NL];

    logic [AW-1:0] act_all;
    assign act_all = {phase_cnt, locked, phases, c7m, cdac};

    function automatic int lane_off(int i);
        if (i < NPH) return i * S;
        if (i == NPH) return 0;
        return FDIV / 4;
    endfunction

    function automatic int lane_div(int i);
        return (i < NPH) ? DIV : FDIV;
    endfunction

    function automatic bit ref_lvl(int c, int off, int d);
        int r;
        r = (((c - off) % d) + d) % d;
        return r < d / 2;
    endfunction

    function automatic logic [2:0] exp_bundle(int i);
        return {m_fall[i], m_rise[i], m_lvl[i]};
    endfunction

    function automatic logic [AW-1:0] exp_all();
        logic [3*NPH-1:0] ph;
        for (int k = 0; k < NPH; k++) ph[3*k +: 3] = exp_bundle(k);
        return {CW'(m_cnt), (m_lock == DIV), ph, exp_bundle(NPH), exp_bundle(NPH+1)};
    endfunction

    function automatic void model_edge(bit e, bit s, bit st, bit r);
        bit nl;
        if (!r) begin
            m_cnt = 0; m_pend = 0; m_lock = 0;
            for (int i = 0; i < NL; i++) begin
                m_lvl[i]  = ref_lvl(0, lane_off(i), lane_div(i));
                m_rise[i] = 0;
                m_fall[i] = 0;
            end
        end else if (e && !st) begin
            if (s || m_pend) begin
                m_cnt = SYNC_VAL; m_pend = 0; m_lock = 0;
            end else begin
                m_cnt = (m_cnt + 1) % DIV;
                if (m_lock < DIV) m_lock++;
            end
            for (int i = 0; i < NL; i++) begin
                nl = ref_lvl(m_cnt, lane_off(i), lane_div(i));
                m_rise[i] = nl && !m_lvl[i];
                m_fall[i] = !nl && m_lvl[i];
                m_lvl[i]  = nl;
            end
        end else begin
            if (s) m_pend = 1;
            for (int i = 0; i < NL; i++) begin
                m_rise[i] = 0;
                m_fall[i] = 0;
            end
        end
    endfunction

    task automatic step(input bit e, input bit s, input bit st, input bit r);
        ena_28m  = e;
        sync_req = s;
        stretch  = st;
        main_rst = r;
        @(posedge main_clk);
        model_edge(e, s, st, r);
        cyc++;
        #1;
    endtask

    // Advance with plain enables until the model counter reaches target.
    task automatic run_to(input int target, input string tag);
        int guard;
        guard = 0;
        while (m_cnt != target && guard < 2*DIV) begin
            step(1, 0, 0, 1);
            guard++;
        end
        n_vec++;
        if (phase_cnt !== CW'(target)) begin
            n_err++;
            $display("FAIL %s_run_to: phase_cnt=%0d required=%0d", tag, phase_cnt, target);
        end
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        n_vec++;
        if (act_all !== exp_all()) begin
            n_err++;
            $display("FAIL reset_state: got=%h required=%h", act_all, exp_all());
        end
        n_vec++;
        if (phases !== 12'h201 || c7m !== 3'b001 || cdac !== 3'b000 || locked !== 1'b0) begin
            n_err++;
            $display("FAIL reset_levels: phases=%h c7m=%b cdac=%b locked=%b required 201/001/000/0",
                     phases, c7m, cdac, locked);
        end
        step(0, 0, 0, 1);
    endtask

    task automatic test_free_run();
        for (int n = 1; n <= 2*DIV; n++) begin
            step(1, 0, 0, 1);
            n_vec++;
            if (act_all !== exp_all()) begin
                n_err++;
                $display("FAIL free_run_state: adv=%0d got=%h required=%h", n, act_all, exp_all());
            end
            if (m_cnt == 0) begin
                n_vec++;
                if (phases[1] !== 1'b1) begin
                    n_err++;
                    $display("FAIL free_p0_rise: got=%b required=1", phases[1]);
                end
            end
            if (m_cnt == 4) begin
                n_vec++;
                if (phases[2] !== 1'b1) begin
                    n_err++;
                    $display("FAIL free_p0_fall: got=%b required=1", phases[2]);
                end
            end
            if (m_cnt == 2) begin
                n_vec++;
                if (phases[4] !== 1'b1) begin
                    n_err++;
                    $display("FAIL free_p1_rise: got=%b required=1", phases[4]);
                end
            end
            if (n == DIV - 1 || n == DIV) begin
                n_vec++;
                if (locked !== (n == DIV)) begin
                    n_err++;
                    $display("FAIL free_lock: adv=%0d locked=%b required=%b", n, locked, n == DIV);
                end
            end
        end
    endtask

    task automatic test_sparse();
        int last_rise;
        int gaps;
        last_rise = -1;
        gaps = 0;
        for (int i = 0; i < 100; i++) begin
            step((i % 4) == 0, 0, 0, 1);
            n_vec++;
            if (act_all !== exp_all()) begin
                n_err++;
                $display("FAIL sparse_state: i=%0d got=%h required=%h", i, act_all, exp_all());
            end
            if (phases[1] === 1'b1) begin
                if (last_rise >= 0) begin
                    gaps++;
                    n_vec++;
                    if (cyc - last_rise != 4*DIV) begin
                        n_err++;
                        $display("FAIL sparse_gap: gap=%0d required=%0d", cyc - last_rise, 4*DIV);
                    end
                end
                last_rise = cyc;
            end
        end
        n_vec++;
        if (gaps < 1) begin
            n_err++;
            $display("FAIL sparse_seen: rise gaps=%0d required>=1", gaps);
        end
    endtask

    task automatic test_stretch();
        logic [3*NPH-1:0] pmask;
        for (int k = 0; k < NPH; k++) pmask[3*k +: 3] = 3'b110;
        run_to(5, "stretch");
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 1);
            n_vec++;
            if (phase_cnt !== CW'(5) || (phases & pmask) !== '0) begin
                n_err++;
                $display("FAIL stretch_hold: cnt=%0d pulses=%h required cnt=5 pulses=0",
                         phase_cnt, phases & pmask);
            end
            step(0, 0, 0, 1);
        end
        step(1, 0, 0, 1);
        n_vec++;
        if (phase_cnt !== CW'(6) || phases[0] !== 1'b0) begin
            n_err++;
            $display("FAIL stretch_release: cnt=%0d p0=%b required cnt=6 p0=0", phase_cnt, phases[0]);
        end
    endtask

    task automatic test_sync_adv();
        run_to(3, "sync_adv");
        step(1, 1, 0, 1);
        n_vec++;
        if (phase_cnt !== CW'(SYNC_VAL) || locked !== 1'b0) begin
            n_err++;
            $display("FAIL sync_adv_cnt: cnt=%0d locked=%b required cnt=%0d locked=0",
                     phase_cnt, locked, SYNC_VAL);
        end
        n_vec++;
        if (phases[11:9] !== 3'b011 || phases[5:3] !== 3'b100 || phases[2:0] !== 3'b001) begin
            n_err++;
            $display("FAIL sync_adv_edges: p3=%b p1=%b p0=%b required 011/100/001",
                     phases[11:9], phases[5:3], phases[2:0]);
        end
        for (int n = 1; n <= DIV; n++) begin
            step(1, 0, 0, 1);
            n_vec++;
            if (locked !== (n == DIV)) begin
                n_err++;
                $display("FAIL sync_relock: adv=%0d locked=%b required=%b", n, locked, n == DIV);
            end
        end
    endtask

    task automatic test_sync_pending();
        logic [CW-1:0] held;
        run_to(5, "pending");
        held = phase_cnt;
        step(0, 1, 0, 1);
        step(0, 0, 0, 1);
        n_vec++;
        if (phase_cnt !== held) begin
            n_err++;
            $display("FAIL pending_hold: cnt=%0d required=%0d", phase_cnt, held);
        end
        step(1, 0, 0, 1);
        n_vec++;
        if (phase_cnt !== CW'(SYNC_VAL) || locked !== 1'b0) begin
            n_err++;
            $display("FAIL pending_load: cnt=%0d locked=%b required cnt=%0d locked=0",
                     phase_cnt, locked, SYNC_VAL);
        end
        step(1, 0, 0, 1);
        n_vec++;
        if (phase_cnt !== CW'((SYNC_VAL + 1) % DIV)) begin
            n_err++;
            $display("FAIL pending_next: cnt=%0d required=%0d", phase_cnt, (SYNC_VAL + 1) % DIV);
        end
    endtask

    task automatic test_reset_mid();
        run_to(6, "reset_mid");
        step(0, 1, 0, 1);
        step(0, 0, 0, 0);
        n_vec++;
        if (phase_cnt !== '0 || locked !== 1'b0 || phases !== 12'h201 ||
            c7m !== 3'b001 || cdac !== 3'b000) begin
            n_err++;
            $display("FAIL reset_mid_state: cnt=%0d locked=%b phases=%h c7m=%b cdac=%b required 0/0/201/001/000",
                     phase_cnt, locked, phases, c7m, cdac);
        end
        step(1, 0, 0, 1);
        n_vec++;
        if (phase_cnt !== CW'(1)) begin
            n_err++;
            $display("FAIL reset_mid_pending_cleared: cnt=%0d required=1", phase_cnt);
        end
    endtask

    task automatic test_random();
        bit e, s, st, r;
        for (int i = 0; i < 1500; i++) begin
            e  = ($urandom % 2) == 0;
            s  = ($urandom % 16) == 0;
            st = ($urandom % 4) == 0;
            r  = ($urandom % 100) != 0;
            step(e, s, st, r);
            n_vec++;
            if (act_all !== exp_all()) begin
                n_err++;
                $display("FAIL random_state: i=%0d got=%h required=%h", i, act_all, exp_all());
            end
        end
    endtask

    initial begin
        main_rst = 1'b0;
        ena_28m  = 1'b0;
        sync_req = 1'b0;
        stretch  = 1'b0;
        m_cnt    = 0;
        m_pend   = 0;
        m_lock   = 0;
        for (int i = 0; i < NL; i++) begin
            m_lvl[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
        end
        test_reset();
        test_free_run();
        test_sparse();
        test_stretch();
        test_sync_adv();
        test_sync_pending();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
